// File: rtl/uart_rx_stream.sv
// UART receiver: 2-flop synchroniser, 8-bit deframer with optional parity,
// small FIFO driving a valid/ready byte stream; line errors as 1-cycle pulses.
`timescale 1ns / 1ps
module uart_rx_stream #(
    parameter int    CLK_FREQ  = 50000000,
    parameter int    BAUD_RATE = 115200,
    parameter string PARITY    = "NONE",
    parameter int    FIFO_AW   = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       i_uart_rx,
    output logic       o_tvalid,
    output logic [7:0] o_tdata,
    input  logic       i_tready,
    output logic       o_err_frame,
    output logic       o_err_par,
    output logic       o_err_ovr
);
    localparam int BAUD_DIV = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
    localparam int CW = $clog2(BAUD_DIV);
    localparam int PW = FIFO_AW + 1;
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);
    localparam logic PAR_EN = (PARITY != "NONE");
    localparam logic PAR_ODD = (PARITY == "ODD");

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_e;

    logic rx_meta_q, rx_s_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= i_uart_rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          par_bad_q;
    logic          push_q;
    logic [7:0]    push_data_q;
    logic          err_frame_q;
    logic          err_par_q;
    logic          tick;

    assign tick = (cnt_q == FULL_M1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            par_bad_q   <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            err_frame_q <= 1'b0;
            err_par_q   <= 1'b0;
        end else begin
            push_q      <= 1'b0;
            err_frame_q <= 1'b0;
            err_par_q   <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (!rx_s_q) state_q <= S_START;
                end
                S_START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q <= '0;
                        if (rx_s_q) begin
                            state_q <= S_IDLE;
                        end else begin
                            state_q   <= S_DATA;
                            bit_q     <= '0;
                            par_bad_q <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s_q, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7)
                            state_q <= PAR_EN ? S_PARITY : S_STOP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_PARITY: begin
                    if (tick) begin
                        cnt_q     <= '0;
                        par_bad_q <= (^shift_q) ^ rx_s_q ^ PAR_ODD;
                        state_q   <= S_STOP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        cnt_q <= '0;
                        if (!rx_s_q) begin
                            err_frame_q <= 1'b1;
                            state_q     <= S_BREAK;
                        end else begin
                            state_q <= S_IDLE;
                            if (par_bad_q) begin
                                err_par_q <= 1'b1;
                            end else begin
                                push_q      <= 1'b1;
                                push_data_q <= shift_q;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_BREAK: begin
                    // a held-low line must not look like a fresh start bit
                    cnt_q <= '0;
                    if (rx_s_q) state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic          full, pop, wr_en, tvalid_d;
    logic          tvalid_q;
    logic [7:0]    tdata_q;

    assign full  = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                   (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
    assign pop   = tvalid_q & i_tready;
    assign wr_en = push_q & (~full | pop);

    always_comb begin
        mem_d = mem_q;
        if (wr_en) mem_d[wptr_q[FIFO_AW-1:0]] = push_data_q;
        wptr_d   = wptr_q + PW'(wr_en);
        rptr_d   = rptr_q + PW'(pop);
        tvalid_d = (wptr_d != rptr_d);
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // output regs track the next head so the head is visible without a bubble
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            tvalid_q <= tvalid_d;
            if (tvalid_d) tdata_q <= mem_d[rptr_d[FIFO_AW-1:0]];
        end
    end

    assign o_tvalid    = tvalid_q;
    assign o_tdata     = tdata_q;
    assign o_err_frame = err_frame_q;
    assign o_err_par   = err_par_q;
    assign o_err_ovr   = push_q & full & ~pop;
endmodule

// File: tb/tb_uart_rx_stream.sv
// Self-checking bench for uart_rx_stream: randomized skewed serial frames
// against a queue-based model of the received byte stream.
`timescale 1ns / 1ps
module tb_uart_rx_stream;
    localparam int CLK_NS  = 20;
    localparam int BIT1_NS = 434 * CLK_NS;
    localparam int BIT2_NS = 50 * CLK_NS;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic rx1 = 1'b1;
    logic rx2 = 1'b1;
    logic rdy1 = 1'b1;
    logic rdy2 = 1'b1;
    logic v1, v2, fe1, pe1, oe1, fe2, pe2, oe2;
    logic [7:0] d1, d2;

    int checks = 0;
    int failures = 0;
    logic [7:0] got1[$];
    logic [7:0] got2[$];
    int nfe1 = 0, npe1 = 0, noe1 = 0;
    int nfe2 = 0, npe2 = 0, noe2 = 0;
    int nstab = 0;
    logic stall = 1'b0;
    logic [7:0] pd = 8'h00;

    always #(CLK_NS / 2) clk = ~clk;

    uart_rx_stream dut1 (
        .clk(clk), .rstn(rstn), .i_uart_rx(rx1),
        .o_tvalid(v1), .o_tdata(d1), .i_tready(rdy1),
        .o_err_frame(fe1), .o_err_par(pe1), .o_err_ovr(oe1)
    );

    uart_rx_stream #(.BAUD_RATE(1000000), .PARITY("EVEN")) dut2 (
        .clk(clk), .rstn(rstn), .i_uart_rx(rx2),
        .o_tvalid(v2), .o_tdata(d2), .i_tready(rdy2),
        .o_err_frame(fe2), .o_err_par(pe2), .o_err_ovr(oe2)
    );

    always @(negedge clk) begin
        if (v1 === 1'b1 && rdy1) got1.push_back(d1);
        if (v2 === 1'b1 && rdy2) got2.push_back(d2);
        nfe1 += int'(fe1 === 1'b1);
        npe1 += int'(pe1 === 1'b1);
        noe1 += int'(oe1 === 1'b1);
        nfe2 += int'(fe2 === 1'b1);
        npe2 += int'(pe2 === 1'b1);
        noe2 += int'(oe2 === 1'b1);
        if (stall && (v1 !== 1'b1 || d1 !== pd)) nstab++;
        stall = (v1 === 1'b1) && !rdy1 && rstn;
        pd = d1;
    end

    function automatic int rskew();
        return int'($urandom_range(2, 0)) * 2 - 2;
    endfunction

    task automatic send1(input logic [7:0] b, input logic stop, input int sk);
        int t;
        t = BIT1_NS * (100 + sk) / 100;
        rx1 = 1'b0;
        #(t);
        for (int i = 0; i < 8; i++) begin
            rx1 = b[i];
            #(t);
        end
        rx1 = stop;
        #(t);
    endtask

    task automatic send2(input logic [7:0] b, input logic par, input int sk);
        int t;
        t = BIT2_NS * (100 + sk) / 100;
        rx2 = 1'b0;
        #(t);
        for (int i = 0; i < 8; i++) begin
            rx2 = b[i];
            #(t);
        end
        rx2 = par;
        #(t);
        rx2 = 1'b1;
        #(t + t / 2);
    endtask

    task automatic idle1();
        rx1 = 1'b1;
        #(BIT1_NS / 2);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({v1, d1, fe1, pe1, oe1} !== 12'h000) begin
            failures++;
            $display("FAIL reset_out1 got=%h exp=000", {v1, d1, fe1, pe1, oe1});
        end
        checks++;
        if ({v2, d2, fe2, pe2, oe2} !== 12'h000) begin
            failures++;
            $display("FAIL reset_out2 got=%h exp=000", {v2, d2, fe2, pe2, oe2});
        end
        @(posedge clk);
        #1 rstn = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({v1, fe1, pe1, oe1} !== 4'h0) begin
            failures++;
            $display("FAIL reset_idle got=%b exp=0000", {v1, fe1, pe1, oe1});
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp[$];
        logic [7:0] b;
        int e0, e;
        got1.delete();
        e0 = nfe1 + npe1 + noe1;
        b = 8'h55;
        send1(b, 1'b1, 2);
        exp.push_back(b);
        idle1();
        b = 8'hA3;
        send1(b, 1'b1, -2);
        exp.push_back(b);
        idle1();
        b = 8'($urandom_range(255, 0));
        send1(b, 1'b1, rskew());
        exp.push_back(b);
        idle1();
        checks++;
        if (got1.size() != exp.size()) begin
            failures++;
            $display("FAIL basic_beats got=%0d exp=%0d", got1.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (got1[i] !== exp[i]) begin
                    failures++;
                    $display("FAIL basic_data[%0d] got=%h exp=%h", i, got1[i], exp[i]);
                end
            end
        end
        e = nfe1 + npe1 + noe1 - e0;
        checks++;
        if (e != 0) begin
            failures++;
            $display("FAIL basic_errors got=%0d exp=0", e);
        end
    endtask

    task automatic test_overrun();
        logic [7:0] m[$];
        int ovr_exp, o0, s0, fp0, n;
        got1.delete();
        ovr_exp = 0;
        o0 = noe1;
        s0 = nstab;
        fp0 = nfe1 + npe1;
        @(posedge clk);
        #1 rdy1 = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            send1(8'(k), 1'b1, rskew());
            idle1();
            if (m.size() < 4) m.push_back(8'(k));
            else ovr_exp++;
        end
        n = noe1 - o0;
        checks++;
        if (n != ovr_exp) begin
            failures++;
            $display("FAIL ovr_pulses got=%0d exp=%0d", n, ovr_exp);
        end
        checks++;
        if (got1.size() != 0) begin
            failures++;
            $display("FAIL ovr_stalled_beats got=%0d exp=0", got1.size());
        end
        @(negedge clk);
        checks++;
        if (v1 !== 1'b1 || d1 !== m[0]) begin
            failures++;
            $display("FAIL ovr_head got=%b/%h exp=1/%h", v1, d1, m[0]);
        end
        @(posedge clk);
        #1 rdy1 = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        checks++;
        if (got1.size() != m.size()) begin
            failures++;
            $display("FAIL ovr_beats got=%0d exp=%0d", got1.size(), m.size());
        end else begin
            for (int i = 0; i < m.size(); i++) begin
                checks++;
                if (got1[i] !== m[i]) begin
                    failures++;
                    $display("FAIL ovr_data[%0d] got=%h exp=%h", i, got1[i], m[i]);
                end
            end
        end
        checks++;
        if (v1 !== 1'b0) begin
            failures++;
            $display("FAIL ovr_drained got=%b exp=0", v1);
        end
        checks++;
        if (nstab - s0 != 0 || nfe1 + npe1 - fp0 != 0) begin
            failures++;
            $display("FAIL ovr_stable got=%0d/%0d exp=0/0", nstab - s0, nfe1 + npe1 - fp0);
        end
    endtask

    task automatic test_break();
        int f0, po0, n, m;
        got1.delete();
        f0 = nfe1;
        po0 = npe1 + noe1;
        send1(8'h7E, 1'b0, rskew());
        #(20 * BIT1_NS);
        idle1();
        idle1();
        send1(8'h42, 1'b1, rskew());
        idle1();
        n = nfe1 - f0;
        m = npe1 + noe1 - po0;
        checks++;
        if (n != 1 || m != 0) begin
            failures++;
            $display("FAIL break_errors got=%0d/%0d exp=1/0", n, m);
        end
        checks++;
        if (got1.size() != 1) begin
            failures++;
            $display("FAIL break_beats got=%0d exp=1", got1.size());
        end else begin
            checks++;
            if (got1[0] !== 8'h42) begin
                failures++;
                $display("FAIL break_data got=%h exp=42", got1[0]);
            end
        end
    endtask

    task automatic test_glitch();
        int e0, e;
        got1.delete();
        e0 = nfe1 + npe1 + noe1;
        rx1 = 1'b0;
        #200;
        rx1 = 1'b1;
        #(BIT1_NS + BIT1_NS / 2);
        e = nfe1 + npe1 + noe1 - e0;
        checks++;
        if (got1.size() != 0 || e != 0) begin
            failures++;
            $display("FAIL glitch got=%0d beats/%0d errs exp=0/0", got1.size(), e);
        end
    endtask

    task automatic test_parity();
        logic [7:0] exp[$];
        logic [7:0] b;
        logic good;
        int perr_exp, p0, fo0, n, m;
        got2.delete();
        perr_exp = 0;
        p0 = npe2;
        fo0 = nfe2 + noe2;
        send2(8'h03, 1'b0, rskew());
        exp.push_back(8'h03);
        send2(8'h03, 1'b1, rskew());
        perr_exp++;
        for (int k = 0; k < 6; k++) begin
            b = 8'($urandom_range(255, 0));
            good = 1'($urandom_range(1, 0));
            send2(b, (^b) ^ !good, rskew());
            if (good) exp.push_back(b);
            else perr_exp++;
        end
        n = npe2 - p0;
        m = nfe2 + noe2 - fo0;
        checks++;
        if (n != perr_exp || m != 0) begin
            failures++;
            $display("FAIL par_errors got=%0d/%0d exp=%0d/0", n, m, perr_exp);
        end
        checks++;
        if (got2.size() != exp.size()) begin
            failures++;
            $display("FAIL par_beats got=%0d exp=%0d", got2.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (got2[i] !== exp[i]) begin
                    failures++;
                    $display("FAIL par_data[%0d] got=%h exp=%h", i, got2[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int e0, e;
        got1.delete();
        e0 = nfe1 + npe1 + noe1;
        rx1 = 1'b0;
        #(BIT1_NS);
        rx1 = 1'b1;
        #(4 * BIT1_NS + BIT1_NS / 2);
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({v1, d1, fe1, pe1, oe1} !== 12'h000) begin
            failures++;
            $display("FAIL rstmid_out got=%h exp=000", {v1, d1, fe1, pe1, oe1});
        end
        @(posedge clk);
        #1 rstn = 1'b1;
        #(5 * BIT1_NS);
        e = nfe1 + npe1 + noe1 - e0;
        checks++;
        if (got1.size() != 0 || e != 0) begin
            failures++;
            $display("FAIL rstmid_quiet got=%0d beats/%0d errs exp=0/0", got1.size(), e);
        end
        send1(8'h11, 1'b1, rskew());
        idle1();
        checks++;
        if (got1.size() != 1) begin
            failures++;
            $display("FAIL rstmid_beats got=%0d exp=1", got1.size());
        end else begin
            checks++;
            if (got1[0] !== 8'h11) begin
                failures++;
                $display("FAIL rstmid_data got=%h exp=11", got1[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_break();
        test_glitch();
        test_parity();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
